// File: rtl/i2c_cmos_ram.sv
// ---------------------------------------------------------------------------
// i2c_cmos_ram
//   I2C responder modelling a PCF8583-style 256x8 CMOS RAM. It sits at the far
//   end of the IOC's bit-banged I2C bus. SCL and SDA arrive as plain control
//   bits, which are asynchronous to clkcpu, so both are synchronised here
//   before any edge detection.
//
//   A host-side port lets the HPS load and save the CMOS image. Host writes
//   take effect only while the I2C bus is idle. Host reads are always valid.
//
// Ports
//   clkcpu     in   1  system clock, the only clock
//   rst_i      in   1  synchronous reset, active-high
//   scl_i      in   1  SCL from the IOC
//   sda_i      in   1  IOC SDA drive, 1 = released
//   sda_o      out  1  responder SDA drive, 1 = released (bus = sda_i & sda_o)
//   busy_o     out  1  high from START through STOP
//   host_addr  in   8  host RAM address
//   host_we    in   1  host write strobe, single cycle
//   host_din   in   8  host write data
//   host_dout  out  8  ram[host_addr], registered, 1-cycle latency
// ---------------------------------------------------------------------------
module i2c_cmos_ram #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clkcpu,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       busy_o,
  input  logic [7:0] host_addr,
  input  logic       host_we,
  input  logic [7:0] host_din,
  output logic [7:0] host_dout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEVADDR,
    S_ACK_DEV,
    S_WORD,
    S_ACK_WORD,
    S_WRITE,
    S_ACK_WR,
    S_READ,
    S_MACK,
    S_IGNORE
  } state_t;

  // Synchroniser stages (s1, s2) and the history flop (h) for each line
  logic       r_scl_s1, r_scl_s2, r_scl_h;
  logic       r_sda_s1, r_sda_s2, r_sda_h;

  state_t     r_state;
  logic [3:0] r_bitcnt;   // bits received, or bits presented while reading
  logic [7:0] r_shift;    // receive / transmit shift register
  logic [7:0] r_ptr;      // word pointer
  logic       r_rw;       // R/W bit of the last matching device address
  logic       r_sda_o;
  logic       r_busy;
  logic [7:0] r_host_dout;
  logic [7:0] r_ram [256];

  logic       w_scl_rise, w_scl_fall;
  logic       w_sda_rise, w_sda_fall;
  logic       w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_last_bit;
  logic       w_i2c_we;
  logic [7:0] w_ram_rd;

  // ---------------------------------------------------------------------------
  // Input synchronisers. They reset to 1 (the idle bus level), so coming out of
  // reset never fakes a START.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the previous
      // value of its neighbour, which gives a true shift chain.
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_sda_rise = r_sda_s2 & ~r_sda_h;
  assign w_sda_fall = ~r_sda_s2 & r_sda_h;

  // START and STOP are SDA transitions while SCL is high.
  assign w_start    = w_sda_fall & r_scl_s2;
  assign w_stop     = w_sda_rise & r_scl_s2;

  // The byte as it stands once the bit on SDA at this rising edge is shifted in.
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_last_bit = (r_bitcnt == 4'd7);
  assign w_ram_rd   = r_ram[r_ptr];

  // A byte is committed only on its eighth SCL rise, and only when that edge
  // is not also a bus condition. A reset therefore never writes a partial byte.
  assign w_i2c_we   = !rst_i && (r_state == S_WRITE) && w_scl_rise &&
                      w_last_bit && !w_start && !w_stop;

  // ---------------------------------------------------------------------------
  // Protocol FSM. START and STOP come first, so they override any SCL edge in
  // the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_shift  <= 8'h00;
      r_ptr    <= 8'h00;
      r_rw     <= 1'b0;
      r_sda_o  <= 1'b1;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_state  <= S_DEVADDR;
      r_bitcnt <= 4'd0;
      r_sda_o  <= 1'b1;
      r_busy   <= 1'b1;
    end else if (w_stop) begin
      r_state  <= S_IDLE;
      r_sda_o  <= 1'b1;
      r_busy   <= 1'b0;
    end else if (w_scl_rise) begin
      case (r_state)
        S_DEVADDR, S_WORD, S_WRITE: begin
          r_shift  <= w_byte;
          r_bitcnt <= r_bitcnt + 4'd1;
          if (w_last_bit) begin
            r_bitcnt <= 4'd0;
            case (r_state)
              S_DEVADDR: begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  r_rw    <= w_byte[0];
                  r_state <= S_ACK_DEV;
                end else begin
                  r_state <= S_IGNORE;
                end
              end
              S_WORD: begin
                r_ptr   <= w_byte;
                r_state <= S_ACK_WORD;
              end
              default: begin
                // The RAM write happens on this same edge, at the old pointer.
                r_ptr   <= r_ptr + 8'd1;
                r_state <= S_ACK_WR;
              end
            endcase
          end
        end
        S_READ: r_bitcnt <= r_bitcnt + 4'd1;
        S_MACK: begin
          // Master acknowledge: 0 asks for another byte, 1 ends the read.
          if (r_sda_s2) r_state <= S_IGNORE;
          else          r_ptr   <= r_ptr + 8'd1;
        end
        default: ;
      endcase
    end else if (w_scl_fall) begin
      case (r_state)
        S_ACK_DEV, S_ACK_WORD, S_ACK_WR: begin
          // Each ack state sees two falls. The first one opens the ack bit, and
          // SDA is still released at that point. The second one closes it.
          if (r_sda_o) begin
            r_sda_o <= 1'b0;
          end else begin
            r_bitcnt <= 4'd0;
            if (r_state == S_ACK_DEV && r_rw) begin
              r_shift <= w_ram_rd;
              r_sda_o <= w_ram_rd[7];
              r_state <= S_READ;
            end else begin
              r_sda_o <= 1'b1;
              r_state <= (r_state == S_ACK_DEV) ? S_WORD : S_WRITE;
            end
          end
        end
        S_READ: begin
          if (r_bitcnt == 4'd8) begin
            r_sda_o <= 1'b1;
            r_state <= S_MACK;
          end else begin
            r_sda_o <= r_shift[6];
            r_shift <= {r_shift[6:0], 1'b0};
          end
        end
        S_MACK: begin
          // This fall can only follow an ACKed master-ack rise. The pointer has
          // already advanced by then.
          r_shift  <= w_ram_rd;
          r_sda_o  <= w_ram_rd[7];
          r_bitcnt <= 4'd0;
          r_state  <= S_READ;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM. The I2C side writes only while busy, and the host side only while
  // idle, so the two writers never collide.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch on purpose. The CMOS image must survive
  // rst_i, and an un-reset array also maps onto plain RAM.
  always_ff @(posedge clkcpu) begin
    if (w_i2c_we) begin
      r_ram[r_ptr] <= w_byte;
    end else if (host_we && !r_busy) begin
      r_ram[host_addr] <= host_din;
    end
  end

  always_ff @(posedge clkcpu) begin
    if (rst_i) r_host_dout <= 8'h00;
    else       r_host_dout <= r_ram[host_addr];
  end

  assign sda_o     = r_sda_o;
  assign busy_o    = r_busy;
  assign host_dout = r_host_dout;

endmodule

// File: tb/tb_i2c_cmos_ram.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmos_ram
//   Bit-bangs an I2C master against i2c_cmos_ram. The expected RAM image and
//   word pointer live in a byte-level model: an array plus an integer pointer,
//   updated per transferred byte.
// ---------------------------------------------------------------------------
module tb_i2c_cmos_ram;

  localparam int P = 4;   // clkcpu cycles per I2C quarter-phase

  logic       clk = 1'b0;
  logic       rst, scl, sda;
  logic       sda_o, busy;
  logic [7:0] haddr, hdin, hdout;
  logic       hwe;

  int checks = 0;
  int errors = 0;
  int low_cnt = 0;

  logic [7:0] mem [256];
  logic [7:0] mptr;
  logic [7:0] wq [$];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] din;
    logic       chk;
    logic [7:0] exp;
  } hvec_t;

  hvec_t tbl [10];

  always #5 clk = ~clk;

  i2c_cmos_ram #(.DEV_ADDR(7'h50)) dut (
    .clkcpu   (clk),
    .rst_i    (rst),
    .scl_i    (scl),
    .sda_i    (sda),
    .sda_o    (sda_o),
    .busy_o   (busy),
    .host_addr(haddr),
    .host_we  (hwe),
    .host_din (hdin),
    .host_dout(hdout)
  );

  // Counts cycles in which the responder pulls SDA low.
  always @(negedge clk) if (sda_o === 1'b0) low_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda = 1'b1; cyc(P);
    scl = 1'b1; cyc(P);
    sda = 1'b0; cyc(P);
    scl = 1'b0; cyc(P);
  endtask

  task automatic i2c_stop();
    sda = 1'b0; cyc(P);
    scl = 1'b1; cyc(P);
    sda = 1'b1; cyc(P);
  endtask

  // Drives one bit and reports the responder's drive while SCL is high.
  task automatic put_bit(input logic b, output logic resp);
    sda = b; cyc(P);
    scl = 1'b1; cyc(P / 2);
    resp = sda_o;
    cyc(P - P / 2);
    scl = 1'b0; cyc(P);
  endtask

  // Releases SDA and samples the wired-AND bus while SCL is high.
  task automatic get_bit(output logic b);
    sda = 1'b1; cyc(P);
    scl = 1'b1; cyc(P / 2);
    b = sda & sda_o;
    cyc(P - P / 2);
    scl = 1'b0; cyc(P);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic dummy, bt;
    for (int i = 7; i >= 0; i--) put_bit(b[i], dummy);
    get_bit(bt);
    ack = ~bt;
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic mack, output logic rel);
    logic bt;
    for (int i = 7; i >= 0; i--) begin
      get_bit(bt);
      b[i] = bt;
    end
    put_bit(~mack, rel);
  endtask

  task automatic host_read(input logic [7:0] a, input string tag);
    haddr = a; cyc(1);
    check($sformatf("%s host_dout[%0h]", tag, a), hdout, mem[a]);
  endtask

  // Write transaction: device byte, word byte, then every byte queued in wq.
  task automatic tx_write(input logic [7:0] dev, input logic [7:0] word, input string tag);
    logic ack;
    logic match;
    match = (dev[7:1] == 7'h50);
    i2c_start();
    wr_byte(dev, ack);
    check({tag, " dev ack"}, ack, match);
    wr_byte(word, ack);
    check({tag, " word ack"}, ack, match);
    if (match) mptr = word;
    foreach (wq[i]) begin
      wr_byte(wq[i], ack);
      check($sformatf("%s data%0d ack", tag, i), ack, match);
      if (match) begin
        mem[mptr] = wq[i];
        mptr = mptr + 8'd1;
      end
    end
    i2c_stop();
    cyc(P);
    check({tag, " busy after stop"}, busy, 1'b0);
  endtask

  // Read transaction of n bytes. The last byte is NACKed, and only ACKs
  // advance the pointer.
  task automatic tx_read(input logic set_word, input logic [7:0] word, input int n,
                         input string tag);
    logic ack, rel;
    logic [7:0] b;
    if (set_word) begin
      i2c_start();
      wr_byte(8'hA0, ack);
      check({tag, " set dev ack"}, ack, 1'b1);
      wr_byte(word, ack);
      check({tag, " set word ack"}, ack, 1'b1);
      mptr = word;
    end
    i2c_start();
    wr_byte(8'hA1, ack);
    check({tag, " rd dev ack"}, ack, 1'b1);
    for (int k = 0; k < n; k++) begin
      rd_byte(b, k != n - 1, rel);
      check($sformatf("%s byte%0d @%0h", tag, k, mptr), b, mem[mptr]);
      check($sformatf("%s mack%0d released", tag, k), rel, 1'b1);
      if (k != n - 1) mptr = mptr + 8'd1;
    end
    i2c_stop();
    cyc(P);
    check({tag, " busy after stop"}, busy, 1'b0);
  endtask

  initial begin
    logic ack;
    logic dummy;
    int   snap;

    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    hwe = 1'b0; haddr = 8'h00; hdin = 8'h00;
    mptr = 8'h00;
    cyc(4);
    check("reset sda_o", sda_o, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset host_dout", hdout, 8'h00);
    rst = 1'b0;
    cyc(4);

    // Give the whole RAM a known random image through the host port.
    for (int a = 0; a < 256; a++) begin
      haddr = 8'(a); hdin = 8'($urandom); hwe = 1'b1;
      mem[a] = hdin;
      cyc(1);
    end
    hwe = 1'b0;

    // Host port table: read data is the RAM content before that row's write.
    tbl[0] = '{1'b1, 8'h40, 8'h77, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h40, 8'h00, 1'b1, 8'h77};
    tbl[2] = '{1'b1, 8'h41, 8'hA5, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'h41, 8'h00, 1'b1, 8'hA5};
    tbl[4] = '{1'b1, 8'h40, 8'h13, 1'b1, 8'h77};
    tbl[5] = '{1'b0, 8'h40, 8'h00, 1'b1, 8'h13};
    tbl[6] = '{1'b0, 8'h41, 8'h00, 1'b1, 8'hA5};
    tbl[7] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00};
    tbl[8] = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h01};
    tbl[9] = '{1'b1, 8'h40, 8'h77, 1'b1, 8'h13};
    for (int i = 0; i < 10; i++) begin
      hwe = tbl[i].we; haddr = tbl[i].addr; hdin = tbl[i].din;
      cyc(1);
      hwe = 1'b0;
      if (tbl[i].chk) check($sformatf("table row%0d host_dout", i), hdout, tbl[i].exp);
      if (tbl[i].we) mem[tbl[i].addr] = tbl[i].din;
    end

    // Basic write.
    wq = '{8'h5A, 8'h3C};
    tx_write(8'hA0, 8'h10, "wr1");
    host_read(8'h10, "wr1");
    host_read(8'h11, "wr1");
    check("wr1 ram10 literal", mem[8'h10], 8'h5A);

    // Random read with a repeated start.
    tx_read(1'b1, 8'h10, 2, "rd2");

    // Wrong address: no ack at all, busy held until STOP, RAM untouched.
    snap = low_cnt;
    i2c_start();
    wr_byte(8'hA4, ack);
    check("wrong dev ack", ack, 1'b0);
    check("wrong busy mid", busy, 1'b1);
    wr_byte(8'h10, ack);
    wr_byte(8'hEE, ack);
    i2c_stop();
    cyc(P);
    check("wrong busy after stop", busy, 1'b0);
    check("wrong sda_o low cycles", low_cnt - snap, 0);
    host_read(8'h10, "wrong");

    // Pointer wrap across FF -> 00.
    wq = '{8'h11, 8'h22};
    tx_write(8'hA0, 8'hFF, "wrap");
    host_read(8'hFF, "wrap");
    host_read(8'h00, "wrap");
    tx_read(1'b1, 8'hFF, 2, "wrapr");

    // Host write during a transfer is dropped.
    i2c_start();
    wr_byte(8'hA0, ack);
    check("hostbusy dev ack", ack, 1'b1);
    check("hostbusy busy", busy, 1'b1);
    haddr = 8'h40; hdin = 8'hEE; hwe = 1'b1; cyc(1); hwe = 1'b0;
    i2c_stop();
    cyc(P);
    host_read(8'h40, "hostbusy");
    check("hostbusy ram40 literal", hdout, 8'h77);

    // Reset in the middle of a data byte.
    wq.delete();
    i2c_start();
    wr_byte(8'hA0, ack);
    check("rst dev ack", ack, 1'b1);
    wr_byte(8'h20, ack);
    check("rst word ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) put_bit(i[0], dummy);
    rst = 1'b1; cyc(1);
    check("rst sda_o", sda_o, 1'b1);
    check("rst busy", busy, 1'b0);
    rst = 1'b0;
    mptr = 8'h00;
    sda = 1'b1; cyc(P);
    scl = 1'b1; cyc(P);
    i2c_start();
    wr_byte(8'hA0, ack);
    check("post-rst dev ack", ack, 1'b1);
    i2c_stop();
    cyc(P);
    host_read(8'h20, "rst");

    // Randomised transactions against the byte-level model.
    for (int t = 0; t < 24; t++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        logic [7:0] dev;
        dev = ($urandom_range(0, 3) == 0) ? {7'($urandom), 1'b0} : 8'hA0;
        wq.delete();
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) wq.push_back(8'($urandom));
        tx_write(dev, 8'($urandom), $sformatf("rnd%0d wr", t));
      end else if (kind == 3) begin
        for (int i = 0; i < 3; i++) host_read(8'($urandom), $sformatf("rnd%0d", t));
      end else begin
        tx_read(1'($urandom), 8'($urandom), int'($urandom_range(1, 3)),
                $sformatf("rnd%0d rd", t));
      end
    end
    for (int i = 0; i < 8; i++) host_read(8'($urandom), "final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
